// File: rtl/top_nondf_kernel_2mm_rd_pkg.sv
// top_nondf_kernel_2mm_rd_pkg: shared state encoding, FIFO sizing and helpers for the A_V read streamer
package top_nondf_kernel_2mm_rd_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   localparam int FIFO_DEPTH = 3;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   function automatic logic [OCC_W-1:0] ptr_inc(input logic [OCC_W-1:0] p);
      return p == OCC_W'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   // A slot must exist for every read still in the RAM pipeline.
   function automatic logic has_room(input logic [OCC_W-1:0] occ, input logic inflight);
      return ({1'b0, occ} + {{OCC_W{1'b0}}, inflight}) < (OCC_W + 1)'(FIFO_DEPTH);
   endfunction
endpackage

// File: rtl/top_nondf_kernel_2mm_rd_fifo.sv
// top_nondf_kernel_2mm_rd_fifo: 3-entry synchronous FIFO holding returned RAM words
module top_nondf_kernel_2mm_rd_fifo
   import top_nondf_kernel_2mm_rd_pkg::*;
#(
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [W-1:0]     din_i,
   output logic [W-1:0]     dout_o,
   output logic [OCC_W-1:0] occ_o,
   output logic             empty_o,
   output logic             full_o
);
   logic [W-1:0]     mem_q [FIFO_DEPTH];
   logic [OCC_W-1:0] wr_q, rd_q, occ_q;
   logic             pop;
   assign pop     = pop_i & ~empty_o;
   assign empty_o = occ_q == '0;
   assign full_o  = occ_q == OCC_W'(FIFO_DEPTH);
   assign occ_o   = occ_q;
   assign dout_o  = mem_q[rd_q];
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_i) mem_q[wr_q] <= din_i;
         wr_q  <= push_i ? ptr_inc(wr_q) : wr_q;
         rd_q  <= pop ? ptr_inc(rd_q) : rd_q;
         occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop);
      end
   end
   a_no_overflow: assert property (@(posedge clk) disable iff (reset) push_i |-> !full_o);
endmodule

// File: rtl/top_nondf_kernel_2mm_a_v_rd_stream.sv
// top_nondf_kernel_2mm_a_v_rd_stream: walks a wrap-around A_V address range and streams words out.
// Optional m_last output via TOP_NONDF_KERNEL_2MM_A_V_RD_STREAM_LAST_EN.
module top_nondf_kernel_2mm_a_v_rd_stream
   import top_nondf_kernel_2mm_rd_pkg::*;
#(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 8,
   parameter int AddressRange = 256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [AddressWidth-1:0] base,
   input  logic [AddressWidth:0]   count,
   output logic                    busy,
   output logic                    done,
   output logic [AddressWidth-1:0] address,
   output logic                    ce,
   output logic                    we,
   output logic [DataWidth-1:0]    d,
   input  logic [DataWidth-1:0]    q,
   output logic                    m_valid,
   output logic [DataWidth-1:0]    m_data,
`ifdef TOP_NONDF_KERNEL_2MM_A_V_RD_STREAM_LAST_EN
   output logic                    m_last,
`endif
   input  logic                    m_ready
);
`ifdef TOP_NONDF_KERNEL_2MM_A_V_RD_STREAM_LAST_EN
   localparam int FW = DataWidth + 1;
`else
   localparam int FW = DataWidth;
`endif
   state_e                  state_q, state_d;
   logic [AddressWidth-1:0] addr_q, addr_d;
   logic [AddressWidth:0]   rem_q, rem_d;
   logic                    inflight_q;
   logic [OCC_W-1:0]        occ;
   logic                    empty, full, pop;
   logic [FW-1:0]           din, dout;
   assign we      = 1'b0;
   assign d       = '0;
   assign address = addr_q;
   assign busy    = state_q == RUN || state_q == DRAIN;
   assign done    = state_q == DONE;
   assign m_valid = ~empty;
   assign pop     = m_valid & m_ready;
   assign ce      = state_q == RUN && rem_q != '0 && !full && has_room(occ, inflight_q);
`ifdef TOP_NONDF_KERNEL_2MM_A_V_RD_STREAM_LAST_EN
   logic last_q;
   assign din    = {last_q, q};
   assign m_data = dout[DataWidth-1:0];
   assign m_last = dout[DataWidth];
   always_ff @(posedge clk) last_q <= reset ? 1'b0 : ce && rem_q == (AddressWidth + 1)'(1);
`else
   assign din    = q;
   assign m_data = dout;
`endif
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = count == '0 ? DONE : RUN;
            addr_d  = base;
            rem_d   = count;
         end
         RUN: if (ce) begin
            addr_d  = addr_q == AddressWidth'(AddressRange - 1) ? '0 : addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = rem_q == (AddressWidth + 1)'(1) ? DRAIN : RUN;
         end
         // Finish on the edge that pops the final beat so done follows it directly.
         DRAIN: if (!inflight_q && (empty || (occ == OCC_W'(1) && pop))) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         inflight_q <= ce;
      end
   end
   top_nondf_kernel_2mm_rd_fifo #(.W(FW)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (inflight_q),
      .pop_i   (pop),
      .din_i   (din),
      .dout_o  (dout),
      .occ_o   (occ),
      .empty_o (empty),
      .full_o  (full)
   );
endmodule

// File: tb/tb_top_nondf_kernel_2mm_a_v_rd_stream.sv
// tb_top_nondf_kernel_2mm_a_v_rd_stream: scoreboard bench with a latency-1 RAM model
module tb_top_nondf_kernel_2mm_a_v_rd_stream;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, m_ready = 1'b1;
   logic [7:0]  base = '0;
   logic [8:0]  count = '0;
   logic        busy, done, ce, we, m_valid;
   logic [7:0]  address;
   logic [31:0] d, m_data, q = '0;
   logic [31:0] mem [256];
   logic [32:0] exp_beats [$];
   logic [7:0]  exp_addr [$];
   logic [32:0] mon_e;
   int          checks = 0, failures = 0, outstanding = 0, pops = 0, done_cnt = 0;
   bit          rnd = 1'b0;
`ifdef TOP_NONDF_KERNEL_2MM_A_V_RD_STREAM_LAST_EN
   logic m_last;
`endif
   top_nondf_kernel_2mm_a_v_rd_stream dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .base    (base),
      .count   (count),
      .busy    (busy),
      .done    (done),
      .address (address),
      .ce      (ce),
      .we      (we),
      .d       (d),
      .q       (q),
      .m_valid (m_valid),
      .m_data  (m_data),
`ifdef TOP_NONDF_KERNEL_2MM_A_V_RD_STREAM_LAST_EN
      .m_last  (m_last),
`endif
      .m_ready (m_ready)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (ce) q <= mem[address];
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask
   // Monitor: pops expected issues and beats, models occupancy + in-flight reads.
   always @(negedge clk) begin
      if (reset) outstanding = 0;
      else begin
         if (done) done_cnt++;
         if (ce) begin
            chk("issue_limit", outstanding < 3, 1);
            chk("ce_requested", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) chk("address", address, exp_addr.pop_front());
         end
         if (m_valid && m_ready) begin
            pops++;
            chk("beat_expected", exp_beats.size() > 0, 1);
            if (exp_beats.size() > 0) begin
               mon_e = exp_beats.pop_front();
               chk("m_data", m_data, mon_e[31:0]);
`ifdef TOP_NONDF_KERNEL_2MM_A_V_RD_STREAM_LAST_EN
               chk("m_last", m_last, mon_e[32]);
`endif
            end
         end
         outstanding += int'(ce) - int'(m_valid && m_ready);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask
   task automatic burst(input int b, input int n, input bit r, input bit poke);
      int k, d0;
      rnd = r;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(8'(b + i));
         exp_beats.push_back({i == n - 1, mem[8'(b + i)]});
      end
      d0 = done_cnt;
      start = 1'b1;
      base  = 8'(b);
      count = 9'(n);
      tick();
      start = 1'b0;
      k = 0;
      if (n == 0) begin
         chk("zero_done", done, 1);
         chk("zero_busy", busy, 0);
      end else begin
         chk("busy_rise", busy, 1);
         chk("m_valid_e0", m_valid, 0);
         tick();
         chk("m_valid_e1", m_valid, 0);
         tick();
         chk("m_valid_e2", m_valid, 1);
         k = 2;
         if (poke) begin
            start = 1'b1;
            base  = 8'h55;
            count = 9'd3;
            tick();
            start = 1'b0;
            k++;
         end
      end
      while (!done && k < n * 8 + 50) begin
         tick();
         k++;
      end
      chk("done_seen", done, 1);
      chk("busy_with_done", busy, 0);
      if (!r) chk("done_latency", k, n == 0 ? 0 : n + 2);
      tick();
      chk("done_pulse", done, 0);
      chk("done_count", done_cnt - d0, 1);
      chk("beats_left", exp_beats.size(), 0);
      chk("issues_left", exp_addr.size(), 0);
   endtask
   initial begin
      int p0;
      for (int i = 0; i < 256; i++) mem[i] = 32'(i * 3);
      reset = 1'b1;
      repeat (3) begin
         tick();
         chk("reset_outputs", {busy, done, ce, address, m_valid}, 0);
      end
      chk("we_d_tied", {we, d}, 0);
      reset = 1'b0;
      tick();
      burst(8'h10, 4, 1'b0, 1'b0);
      burst(8'hFE, 4, 1'b0, 1'b0);
      burst(8'h20, 8, 1'b1, 1'b0);
      burst(8'h40, 0, 1'b0, 1'b0);
      burst(8'h00, 256, 1'b0, 1'b0);
      burst(8'h80, 6, 1'b0, 1'b1);
      rnd = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_addr.push_back(8'(8'h30 + i));
         exp_beats.push_back({i == 7, mem[8'h30 + i]});
      end
      p0 = pops;
      start = 1'b1;
      base  = 8'h30;
      count = 9'd8;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20 && pops - p0 < 2; i++) tick();
      chk("abort_two_beats", pops - p0 >= 2, 1);
      reset = 1'b1;
      tick();
      chk("abort_outputs", {m_valid, ce, busy}, 0);
      exp_addr.delete();
      exp_beats.delete();
      reset = 1'b0;
      tick();
      burst(8'h05, 5, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
